// File: rtl/event_serializer_pkg.sv
// event_serializer_pkg
//   Shared definitions for the event serializer and its upstream packer:
//   - log2: index-width helper (ceil(log2(value)), minimum 1).
//   - state_e: IDLE/SEND state encoding for the serializer FSM.
package event_serializer_pkg;

    // Bits needed to hold value-1 (ceil(log2(value))), never less than 1 so
    // that degenerate sizes still produce a legal vector width.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

endpackage

// File: rtl/event_serializer.sv
// event_serializer
//   Takes one packed set of valid entry indices plus the per-entry event words
//   from the event-capture packer and emits the valid events one word per
//   valid/ready transfer, in packed order. A new set is accepted only in IDLE;
//   sets arriving while a set is being sent are dropped and counted.
//
// Ports:
//   clk                in   clock
//   reset              in   asynchronous active-high reset
//   ordered_entries    in   packed entry indices, slot k at [k*NUM_ENTRIES_SIZE +: NUM_ENTRIES_SIZE]
//   num_valid_entries  in   number of valid slots (clamped to NUM_ENTRIES)
//   event_data         in   event word for entry i at [i*EVT_WIDTH +: EVT_WIDTH]
//   pack_vld           in   single-cycle strobe marking a new set
//   in_rdy             out  idle, a pack_vld will be accepted
//   out_vld            out  out_data is valid
//   out_rdy            in   downstream accepts the word
//   out_data           out  current event word
//   out_entry          out  source entry index of out_data
//   out_last           out  current word is the last of the set
//   drop_cnt           out  saturating count of dropped sets
module event_serializer
    import event_serializer_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES      = 9,
    parameter int unsigned NUM_ENTRIES_SIZE = log2(NUM_ENTRIES),
    parameter int unsigned ALL_ENTRIES_SIZE = NUM_ENTRIES * NUM_ENTRIES_SIZE,
    parameter int unsigned EVT_WIDTH        = 32,
    parameter int unsigned DROP_CNT_WIDTH   = 16,
    parameter int unsigned CNT_WIDTH        = log2(NUM_ENTRIES + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ALL_ENTRIES_SIZE-1:0]      ordered_entries,
    input  logic [CNT_WIDTH-1:0]             num_valid_entries,
    input  logic [NUM_ENTRIES*EVT_WIDTH-1:0] event_data,
    input  logic                             pack_vld,
    output logic                             in_rdy,
    output logic                             out_vld,
    input  logic                             out_rdy,
    output logic [EVT_WIDTH-1:0]             out_data,
    output logic [NUM_ENTRIES_SIZE-1:0]      out_entry,
    output logic                             out_last,
    output logic [DROP_CNT_WIDTH-1:0]        drop_cnt
);

    localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(NUM_ENTRIES);

    state_e                       state_q;
    logic [NUM_ENTRIES_SIZE-1:0]  idx_q;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic [ALL_ENTRIES_SIZE-1:0]  entries_q;
    logic [NUM_ENTRIES*EVT_WIDTH-1:0] data_q;
    logic [DROP_CNT_WIDTH-1:0]    drop_cnt_q;

    logic                         sending;
    logic [NUM_ENTRIES_SIZE-1:0]  cur_entry;
    logic                         cur_last;
    logic [CNT_WIDTH-1:0]         num_clamped;

    assign sending     = (state_q == StSend);
    assign num_clamped = (num_valid_entries > MaxCnt) ? MaxCnt : num_valid_entries;

    // Everything below is a mux of registered state, so the word on the bus
    // cannot change while a transfer is stalled.
    always_comb begin
        cur_entry = entries_q[int'(idx_q) * NUM_ENTRIES_SIZE +: NUM_ENTRIES_SIZE];
        cur_last  = ((CNT_WIDTH'(idx_q) + CNT_WIDTH'(1)) == cnt_q);

        out_vld   = sending;
        out_entry = '0;
        out_data  = '0;
        out_last  = 1'b0;
        if (sending) begin
            out_entry = cur_entry;
            out_last  = cur_last;
            // A corrupt index from upstream yields a zero word rather than X.
            if (int'(cur_entry) < int'(NUM_ENTRIES)) begin
                out_data = data_q[int'(cur_entry) * EVT_WIDTH +: EVT_WIDTH];
            end
        end
    end

    // Gated by reset so upstream never sees ready while the block is held.
    assign in_rdy   = (state_q == StIdle) & ~reset;
    assign drop_cnt = drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            entries_q  <= '0;
            data_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // An empty set is ignored and does not count as a drop.
                    if (pack_vld && (num_valid_entries != '0)) begin
                        entries_q <= ordered_entries;
                        data_q    <= event_data;
                        cnt_q     <= num_clamped;
                        idx_q     <= '0;
                        state_q   <= StSend;
                    end
                end
                StSend: begin
                    if (pack_vld && (drop_cnt_q != '1)) begin
                        drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
                    end
                    if (out_rdy) begin
                        if (cur_last) begin
                            state_q <= StIdle;
                        end else begin
                            idx_q <= idx_q + NUM_ENTRIES_SIZE'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/event_serializer.md
Name: event_serializer

Overview:
- Sits directly downstream of the event-capture packer. It takes one packed set of valid entry indices plus the matching per-entry event words.
- It emits the valid events one word per transfer, in packed order, over a valid/ready interface toward the event output FIFO.
- It accepts a new set only when idle. Sets that arrive while busy are dropped and counted.

Parameters:
- NUM_ENTRIES, 9, number of event sources; must match the packer.
- NUM_ENTRIES_SIZE, log2(NUM_ENTRIES), width of one entry index.
- ALL_ENTRIES_SIZE, NUM_ENTRIES*NUM_ENTRIES_SIZE, width of the packed index vector.
- EVT_WIDTH, 32, width of one event word.
- DROP_CNT_WIDTH, 16, width of the dropped-set counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ordered_entries  in  ALL_ENTRIES_SIZE  packed entry indices from the packer; slot k is bits [k*NUM_ENTRIES_SIZE +: NUM_ENTRIES_SIZE].
- num_valid_entries  in  log2(NUM_ENTRIES+1)  count of valid slots.
- event_data  in  NUM_ENTRIES*EVT_WIDTH  event word for entry i at bits [i*EVT_WIDTH +: EVT_WIDTH]; aligned with the packer outputs.
- pack_vld  in  1  single-cycle strobe: the inputs above form a new set this cycle.
- in_rdy  out  1  block is idle and will accept pack_vld.
- out_vld  out  1  out_data is valid.
- out_rdy  in  1  downstream accepts the word.
- out_data  out  EVT_WIDTH  current event word.
- out_entry  out  NUM_ENTRIES_SIZE  source entry index of out_data.
- out_last  out  1  current word is the last word of the set.
- drop_cnt  out  DROP_CNT_WIDTH  number of dropped sets, saturating.

Behaviour:
- States: IDLE, SEND.
- A transfer occurs on any cycle with out_vld & out_rdy.
- Reset (asynchronous, takes effect immediately, including mid-set):
  - State goes to IDLE; slot index and latched count are cleared.
  - Latched index and data registers are cleared to 0.
  - drop_cnt clears to 0; out_vld, out_last, out_data and out_entry are 0.
  - in_rdy is 0 while reset is asserted.
- in_rdy = (state == IDLE) & ~reset. It is purely state-based, with no combinational path from out_rdy.
- IDLE with pack_vld and num_valid_entries > 0:
  - Latch ordered_entries, event_data and the count (values above NUM_ENTRIES clamp to NUM_ENTRIES).
  - Set slot index to 0 and go to SEND.
  - out_vld rises on the next cycle, giving one cycle of latency from pack_vld.
- IDLE with pack_vld and num_valid_entries == 0: the set is ignored; stay in IDLE; no drop is counted.
- Output decode in SEND:
  - out_vld = 1.
  - out_entry = latched index in slot[idx].
  - out_data = latched event word selected by out_entry.
  - out_last = (idx == count-1).
  - All outputs are driven from registers through the mux, so they stay stable until the transfer.
- On a transfer in SEND:
  - If out_last: go to IDLE; out_vld drops next cycle.
  - Otherwise: idx increments.
- Back-to-back sets: there is at least one idle cycle between sets, because in_rdy rises the cycle after the last transfer.
- pack_vld while not in_rdy (in SEND): the set is discarded and drop_cnt increments. drop_cnt saturates at all-ones. The current set's output stream is unaffected.
- out_vld never deasserts without a transfer, except on reset.
- Outside SEND, out_data, out_entry and out_last are 0.

Decomposition:
- Shared package/include holds:
  - the log2 function (same definition as the packer);
  - the IDLE/SEND state encoding constants.
- No sub-module is needed: the index/word select is one indexed part-select.
- The packer remains a separate instance upstream.

Test Plan (NUM_ENTRIES=9, EVT_WIDTH=32, event_data[i]=32'hA0+i):
- Reset held for 3 cycles, then released -> out_vld=0 and drop_cnt=0 throughout; in_rdy=0 during reset and 1 on the first cycle after release.
- pack_vld with valid mask 9'b1_0000_0101 (ordered 0,2,8; num=3), out_rdy=1 -> out_data A0, A2, A8 on consecutive cycles starting one cycle after pack_vld; out_entry 0, 2, 8; out_last only on A8; in_rdy=1 on the cycle after the A8 transfer.
- Same set with out_rdy pattern 1,0,0,1,0,1 -> A0 transfers; A2 is held stable for 2 stall cycles, then transfers; A8 is held 1 cycle, then transfers with out_last=1; no words are lost or duplicated.
- Second pack_vld during SEND of a 3-word set -> drop_cnt=1; output stream is still exactly A0, A2, A8.
- pack_vld with num_valid_entries=0 -> out_vld stays 0, in_rdy stays 1, drop_cnt unchanged.
- All 9 entries valid, out_rdy=1, reset asserted after the 4th transfer -> out_vld=0 immediately. After release, a new set (mask 9'b0_0001_0000) yields the single word A4 with out_last=1.
